// File: rtl/bit_serializer.sv
// bit_serializer: WIDTH-bit parallel words in over valid/ready, one bit per cycle out.
// Define SER_PARITY_EN to append an even-parity bit after each word's data bits.
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_msb_first,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    LAST_GAP = 4'(GAP - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP_WAIT} state_t;
`endif

  state_t           state, state_next, after_word;
  logic [WIDTH-1:0] hold_data, shift_reg;
  logic             hold_msb, hold_full, msb_order;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             shift_last, final_emit, gap_last, load_now, handshake;
  logic             sout_next, sout_valid_next;
`ifdef SER_PARITY_EN
  logic             parity_bit;
`endif

  // The buffer refills on the same edge it drains, so din_ready looks at load_now.
  always_comb begin
    shift_last = (state == SHIFT) && (bit_cnt == LAST_BIT);
    gap_last   = (state == GAP_WAIT) && ((GAP == 0) || (gap_cnt == LAST_GAP));
`ifdef SER_PARITY_EN
    final_emit = (state == PARITY);
`else
    final_emit = shift_last;
`endif
    load_now   = hold_full && ((state == IDLE) || (final_emit && (GAP == 0)) || gap_last);
  end

  assign din_ready = !hold_full || load_now;
  assign handshake = din_valid && din_ready;
  assign busy      = (state != IDLE);
  assign word_done = final_emit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    after_word = (GAP > 0) ? GAP_WAIT : (load_now ? SHIFT : IDLE);
    case (state)
      IDLE:     if (load_now) state_next = SHIFT;
`ifdef SER_PARITY_EN
      SHIFT:    if (shift_last) state_next = PARITY;
      PARITY:   state_next = after_word;
`else
      SHIFT:    if (shift_last) state_next = after_word;
`endif
      GAP_WAIT: if (gap_last) state_next = load_now ? SHIFT : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Next serial bit is chosen here so sout/sout_valid can be registered.
  always_comb begin
    sout_next       = 1'b0;
    sout_valid_next = 1'b0;
    if (load_now) begin
      sout_next       = hold_msb ? hold_data[WIDTH-1] : hold_data[0];
      sout_valid_next = 1'b1;
    end else if ((state == SHIFT) && !shift_last) begin
      sout_next       = msb_order ? shift_reg[WIDTH-2] : shift_reg[1];
      sout_valid_next = 1'b1;
    end
`ifdef SER_PARITY_EN
    else if (shift_last) begin
      sout_next       = parity_bit;
      sout_valid_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_msb   <= 1'b0;
      hold_full  <= 1'b0;
      shift_reg  <= '0;
      msb_order  <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= 4'd0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
`ifdef SER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      sout       <= sout_next;
      sout_valid <= sout_valid_next;
      if (handshake) begin
        hold_data <= din;
        hold_msb  <= din_msb_first;
        hold_full <= 1'b1;
      end else if (load_now) begin
        hold_full <= 1'b0;
      end
      if (load_now) begin
        shift_reg  <= hold_data;
        msb_order  <= hold_msb;
        bit_cnt    <= '0;
`ifdef SER_PARITY_EN
        parity_bit <= ^hold_data;
`endif
      end else if ((state == SHIFT) && !shift_last) begin
        shift_reg <= msb_order ? (shift_reg << 1) : (shift_reg >> 1);
        bit_cnt   <= bit_cnt + CW'(1);
      end
      gap_cnt <= (state == GAP_WAIT) ? gap_cnt + 4'd1 : 4'd0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed words, streams and reset, checked against a word-level model.
// Define SER_PARITY_EN for both RTL and bench to cover the parity bit.
module tb_bit_serializer;

  localparam int WIDTH = 8;
  localparam int GAP_B = 3;
`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = WIDTH + PB;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din, g_din;
  logic             din_msb_first, din_valid, g_din_msb_first, g_din_valid;
  logic             din_ready, sout, sout_valid, busy, word_done;
  logic             g_din_ready, g_sout, g_sout_valid, g_busy, g_word_done;
  int               n_tests = 0;
  int               n_fail  = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(WIDTH), .GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_msb_first(din_msb_first),
    .din_valid(din_valid), .din_ready(din_ready), .sout(sout),
    .sout_valid(sout_valid), .busy(busy), .word_done(word_done)
  );

  bit_serializer #(.WIDTH(WIDTH), .GAP(GAP_B)) dut_gap (
    .clk(clk), .rst_n(rst_n), .din(g_din), .din_msb_first(g_din_msb_first),
    .din_valid(g_din_valid), .din_ready(g_din_ready), .sout(g_sout),
    .sout_valid(g_sout_valid), .busy(g_busy), .word_done(g_word_done)
  );

  // Reference: i-th emitted bit of a word (index WIDTH is the parity bit).
  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input logic msb, input int i);
    if (i >= WIDTH) return ^w;
    return msb ? w[WIDTH-1-i] : w[i];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    din = '0; din_msb_first = 1'b0; din_valid = 1'b0;
    g_din = '0; g_din_msb_first = 1'b0; g_din_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({sout, sout_valid, busy, word_done, din_ready} !== 5'b00001) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b expected 00001", {sout, sout_valid, busy, word_done, din_ready});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({sout_valid, busy, g_sout_valid, g_busy, din_ready, g_din_ready} !== 6'b000011) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: got %b expected 000011",
               {sout_valid, busy, g_sout_valid, g_busy, din_ready, g_din_ready});
    end
  endtask

  task automatic test_single(input logic [WIDTH-1:0] w, input logic m, input bit use_lit,
                             input logic [WIDTH-1:0] lit, input logic lit_par);
    logic [NB-1:0] gotw, expw, vw, dw, edw;
    gotw = '0; expw = '0; vw = '0; dw = '0; edw = '0;
    @(negedge clk);
    din = w; din_msb_first = m; din_valid = 1'b1;
    n_tests++;
    if (din_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL single_ready: got %b expected 1", din_ready);
    end
    @(negedge clk);
    din_valid = 1'b0;
    n_tests++;
    if (sout_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL single_latency: sout_valid got %b expected 0", sout_valid);
    end
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      gotw = {gotw[NB-2:0], sout};
      vw   = {vw[NB-2:0], sout_valid};
      dw   = {dw[NB-2:0], word_done};
      expw = {expw[NB-2:0], exp_bit(w, m, i)};
      edw  = {edw[NB-2:0], (i == NB - 1)};
    end
    n_tests++;
    if (gotw !== expw) begin
      n_fail++; $display("[TB] FAIL single_bits w=%h m=%b: got %b expected %b", w, m, gotw, expw);
    end
    n_tests++;
    if ((vw !== {NB{1'b1}}) || (dw !== edw)) begin
      n_fail++; $display("[TB] FAIL single_valid_done: got valid %b done %b expected valid all-1 done %b", vw, dw, edw);
    end
    if (use_lit) begin
      n_tests++;
      if (gotw[NB-1 -: WIDTH] !== lit) begin
        n_fail++; $display("[TB] FAIL single_pattern w=%h: got %b expected %b", w, gotw[NB-1 -: WIDTH], lit);
      end
`ifdef SER_PARITY_EN
      n_tests++;
      if (gotw[0] !== lit_par) begin
        n_fail++; $display("[TB] FAIL parity_bit w=%h: got %b expected %b", w, gotw[0], lit_par);
      end
`endif
    end
    @(negedge clk);
    n_tests++;
    if ({sout_valid, sout, busy, word_done} !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL single_idle_after: got %b expected 0000", {sout_valid, sout, busy, word_done});
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] words[$];
    logic             msbs[$];
    bit               exp_q[$], got_q[$];
    int sent = 0, run = 0, max_run = 0, cyc = 0, bad_hs = 0, bad_bits = 0;
    bit saw_not_ready = 0;
    words = '{8'h05, 8'h0D, 8'h03};
    msbs  = '{1'b1, 1'b1, 1'b1};
    repeat (2) begin
      words.push_back(WIDTH'($urandom));
      msbs.push_back(1'($urandom));
    end
    @(negedge clk);
    while ((sent < words.size() || got_q.size() < words.size() * NB) && cyc < 400) begin
      if (sout_valid) begin
        got_q.push_back(sout);
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (sent < words.size()) begin
        din = words[sent]; din_msb_first = msbs[sent]; din_valid = 1'b1;
        if (!din_ready) saw_not_ready = 1;
        else begin
          if (sent >= 2 && !word_done) bad_hs++;
          for (int i = 0; i < NB; i++) exp_q.push_back(exp_bit(words[sent], msbs[sent], i));
          sent++;
        end
      end else din_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    din_valid = 1'b0;
    n_tests++;
    if (cyc >= 400) begin
      n_fail++; $display("[TB] FAIL b2b_timeout: got %0d bits expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad_bits++;
    n_tests++;
    if (bad_bits != 0 || got_q.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL b2b_bits: got %0d wrong of %0d expected 0 wrong of %0d", bad_bits, got_q.size(), exp_q.size());
    end
    n_tests++;
    if (max_run != words.size() * NB) begin
      n_fail++; $display("[TB] FAIL b2b_continuous: got run %0d expected %0d", max_run, words.size() * NB);
    end
    n_tests++;
    if (!saw_not_ready || bad_hs != 0) begin
      n_fail++; $display("[TB] FAIL b2b_handshake: got not_ready_seen=%0d off_reload=%0d expected 1 and 0", saw_not_ready, bad_hs);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_gap();
    logic [WIDTH-1:0] w[2];
    logic             m[2];
    logic             ev, es, eb;
    int bad = 0, first_bad = -1, idle_between = 0, seg, wi;
    logic [2:0] bad_got, bad_exp;
    bad_got = '0; bad_exp = '0;
    for (int k = 0; k < 2; k++) begin
      w[k] = WIDTH'($urandom); m[k] = 1'($urandom);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      g_din = w[k]; g_din_msb_first = m[k]; g_din_valid = 1'b1;
      n_tests++;
      if (g_din_ready !== 1'b1) begin
        n_fail++; $display("[TB] FAIL gap_ready word%0d: got %b expected 1", k, g_din_ready);
      end
    end
    @(negedge clk);
    g_din_valid = 1'b0;
    for (int c = 0; c < 2 * (NB + GAP_B) + 2; c++) begin
      wi = c / (NB + GAP_B);
      seg = c % (NB + GAP_B);
      if (wi < 2) begin
        ev = (seg < NB); es = ev ? exp_bit(w[wi], m[wi], seg) : 1'b0; eb = 1'b1;
      end else begin
        ev = 1'b0; es = 1'b0; eb = 1'b0;
      end
      if (c >= NB && c < 2 * NB + GAP_B && !g_sout_valid) idle_between++;
      if ({g_sout_valid, g_sout, g_busy} !== {ev, es, eb}) begin
        bad++;
        if (first_bad < 0) begin
          first_bad = c; bad_got = {g_sout_valid, g_sout, g_busy}; bad_exp = {ev, es, eb};
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("[TB] FAIL gap_trace cycle %0d: got valid/sout/busy %b expected %b (%0d bad cycles)",
                         first_bad, bad_got, bad_exp, bad);
    end
    n_tests++;
    if (idle_between != GAP_B) begin
      n_fail++; $display("[TB] FAIL gap_length: got %0d idle cycles expected %0d", idle_between, GAP_B);
    end
  endtask

  task automatic test_random();
    bit exp_q[$], got_q[$];
    logic [WIDTH-1:0] w;
    logic m;
    int words = 0, cyc = 0, done_cnt = 0, bad_done = 0, bad_bits = 0;
    @(negedge clk);
    while ((words < 20 || got_q.size() < words * NB) && cyc < 2000) begin
      if (sout_valid) got_q.push_back(sout);
      if (word_done) begin
        done_cnt++;
        if (!sout_valid) bad_done++;
      end
      if (words < 20) begin
        w = WIDTH'($urandom); m = 1'($urandom);
        din = w; din_msb_first = m;
        din_valid = ($urandom_range(0, 2) != 0);
        if (din_valid && din_ready) begin
          for (int i = 0; i < NB; i++) exp_q.push_back(exp_bit(w, m, i));
          words++;
        end
      end else din_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    din_valid = 1'b0;
    n_tests++;
    if (cyc >= 2000) begin
      n_fail++; $display("[TB] FAIL random_timeout: got %0d bits expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad_bits++;
    n_tests++;
    if (bad_bits != 0 || got_q.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL random_bits: got %0d wrong of %0d expected 0 wrong of %0d", bad_bits, got_q.size(), exp_q.size());
    end
    n_tests++;
    if (done_cnt != words || bad_done != 0) begin
      n_fail++; $display("[TB] FAIL random_word_done: got %0d pulses (%0d stray) expected %0d", done_cnt, bad_done, words);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    bit seen = 0;
    @(negedge clk);
    din = 8'hFF; din_msb_first = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din = 8'h00; din_msb_first = 1'b1;
    n_tests++;
    if (din_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", din_ready);
    end
    @(negedge clk);
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if ({sout_valid, sout, din_ready} !== 3'b110) begin
      n_fail++; $display("[TB] FAIL rst_mid_bit4: got %b expected 110", {sout_valid, sout, din_ready});
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({sout, sout_valid, busy, word_done, din_ready} !== 5'b00001) begin
      n_fail++; $display("[TB] FAIL rst_mid_async: got %b expected 00001", {sout, sout_valid, busy, word_done, din_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * NB) begin
      @(negedge clk);
      if (sout_valid || busy) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("[TB] FAIL rst_mid_no_resume: got activity 1 expected 0");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single(8'hA5, 1'b1, 1'b1, 8'b10100101, 1'b0);
    test_single(8'hA5, 1'b0, 1'b1, 8'b10100101, 1'b0);
    test_single(8'h0B, 1'b0, 1'b1, 8'b11010000, 1'b1);
    test_single(8'h07, 1'b1, 1'b1, 8'b00000111, 1'b1);
    test_single(8'h03, 1'b1, 1'b1, 8'b00000011, 1'b0);
    test_back_to_back();
    test_gap();
    test_random();
    test_reset_mid_word();
    test_single(WIDTH'($urandom), 1'($urandom), 1'b0, '0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
